sha512_pad: RTL and testbench

SHA512_PAD -- requirements
Module: sha512_pad

---
 rtl/sha512_pkg.sv | 21 ++
 rtl/sha512_pad_if.sv | 25 ++
 rtl/sha512_pad.sv | 129 ++++++++++++
 tb/tb_sha512_pad.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha512_pkg.sv
// Shared SHA-512 front-end definitions: block geometry, padding constants,
// the sequencer state encoding and the length-field helper.
package sha512_pkg;

    localparam int         CHUNK_BYTES = 128;
    localparam int         LEN_OFFSET  = 112;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_LEN  = 2'd2,
        ST_EMIT = 2'd3
    } sha512_state_e;

    // 128-bit big-endian message length in bits, from a byte count.
    function automatic logic [127:0] len_field(input logic [63:0] nbytes);
        return {61'b0, nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha512_pad_if.sv
// Byte-stream input and padded-block output handshakes of the SHA-512 padder.
interface sha512_pad_if;
    import sha512_pkg::*;

    logic [7:0]               in_byte;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_empty;
    logic                     in_ready;
    logic [CHUNK_BYTES*8-1:0] chunk;
    logic                     chunk_valid;
    logic                     chunk_ready;
    logic                     chunk_last;

    modport master (
        output in_byte, in_valid, in_last, in_empty, chunk_ready,
        input  in_ready, chunk, chunk_valid, chunk_last
    );

    modport slave (
        input  in_byte, in_valid, in_last, in_empty, chunk_ready,
        output in_ready, chunk, chunk_valid, chunk_last
    );

endinterface

// File: rtl/sha512_pad.sv
// SHA-512 message padder: packs a byte stream into 128-byte blocks, appends
// the 0x80 marker, zero fill and 128-bit length, and flags the final block.
module sha512_pad
    import sha512_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    sha512_pad_if.slave bus
);

    localparam logic [1:0] S_FILL = ST_FILL;
    localparam logic [1:0] S_PAD  = ST_PAD;
    localparam logic [1:0] S_LEN  = ST_LEN;
    localparam logic [1:0] S_EMIT = ST_EMIT;

    logic [1:0]    state;
    logic [7:0]    r;
    logic [63:0]   len;
    logic          pad_pend;
    logic          len_pend;
    logic          last_q;
    logic [1023:0] chunk_q;
    logic [1023:0] pad_next;
    logic [7:0]    r_inc;
    logic          in_fire;
    logic          out_fire;

    // Marker at byte pos, zeros after it, length field when it still fits.
    function automatic logic [1023:0] pad_block(input logic [1023:0] b,
                                                input logic [7:0]    pos,
                                                input logic [63:0]   nbytes);
        logic [1023:0] o;
        o = b;
        for (int i = 0; i < CHUNK_BYTES; i++) begin
            if (8'(i) == pos)
                o[1023-8*i -: 8] = PAD_BYTE;
            else if (8'(i) > pos)
                o[1023-8*i -: 8] = 8'h00;
        end
        if (pos < 8'(LEN_OFFSET))
            o[127:0] = len_field(nbytes);
        return o;
    endfunction

    assign in_fire  = bus.in_valid && (state == S_FILL);
    assign out_fire = bus.chunk_ready && (state == S_EMIT);
    assign r_inc    = r + 8'd1;

    always_comb pad_next = pad_block(chunk_q, r, len);

    assign bus.in_ready    = (state == S_FILL);
    assign bus.chunk_valid = (state == S_EMIT);
    assign bus.chunk       = chunk_q;
    assign bus.chunk_last  = last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FILL;
            r        <= 8'd0;
            len      <= 64'd0;
            pad_pend <= 1'b0;
            len_pend <= 1'b0;
            last_q   <= 1'b0;
            chunk_q  <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_fire) begin
                        if (bus.in_empty) begin
                            // Zero-length message: nothing to store, go pad.
                            if (bus.in_last) begin
                                pad_pend <= 1'b1;
                                state    <= S_PAD;
                            end
                        end else begin
                            chunk_q[{~r[6:0], 3'b111} -: 8] <= bus.in_byte;
                            r   <= r_inc;
                            len <= len + 64'd1;
                            if (bus.in_last)
                                pad_pend <= 1'b1;
                            if (r_inc == 8'(CHUNK_BYTES)) begin
                                last_q <= 1'b0;
                                state  <= S_EMIT;
                            end else if (bus.in_last) begin
                                state <= S_PAD;
                            end
                        end
                    end
                end
                S_PAD: begin
                    chunk_q  <= pad_next;
                    pad_pend <= 1'b0;
                    state    <= S_EMIT;
                    if (r < 8'(LEN_OFFSET)) begin
                        last_q <= 1'b1;
                    end else begin
                        last_q   <= 1'b0;
                        len_pend <= 1'b1;
                    end
                end
                S_LEN: begin
                    chunk_q  <= {{(1024-128){1'b0}}, len_field(len)};
                    len_pend <= 1'b0;
                    last_q   <= 1'b1;
                    state    <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_fire) begin
                        chunk_q <= '0;
                        r       <= 8'd0;
                        last_q  <= 1'b0;
                        if (len_pend) begin
                            state <= S_LEN;
                        end else if (pad_pend) begin
                            state <= S_PAD;
                        end else if (last_q) begin
                            len   <= 64'd0;
                            state <= S_FILL;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_pad.sv
// Self-checking bench for sha512_pad: directed padding corner cases plus
// random messages with random input gaps and output back-pressure.
module tb_sha512_pad;

    logic clk = 1'b0;
    logic reset;

    sha512_pad_if bus();

    sha512_pad dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]    cur_msg[$];
    bit            cur_empty;
    int            gap_pct;
    int            rdy_pct;
    int            stall_cycles;
    int            last_acc_cyc;
    int            first_vld_cyc;
    logic [1023:0] exp_q[$];
    bit            exp_last[$];

    localparam int LIMIT = 2000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: message || 0x80 || zeros to 112 mod 128 || 128-bit bit length.
    task automatic build_expected();
        logic [7:0]    p[$];
        logic [127:0]  bits;
        logic [1023:0] blk;
        int            nb;
        p = cur_msg;
        p.push_back(8'h80);
        while (p.size() % 128 != 112) p.push_back(8'h00);
        bits = 128'(cur_msg.size()) * 128'd8;
        for (int i = 15; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nb = p.size() / 128;
        exp_q.delete();
        exp_last.delete();
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int j = 0; j < 128; j++) blk[1023-8*j -: 8] = p[b*128+j];
            exp_q.push_back(blk);
            exp_last.push_back(b == nb - 1);
        end
    endtask

    task automatic drive_msg(input string name);
        int nbeats;
        int idx;
        int waitc;
        nbeats = cur_empty ? 1 : cur_msg.size();
        idx    = 0;
        waitc  = 0;
        while (idx < nbeats && waitc < LIMIT) begin
            @(posedge clk); #1;
            if (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_empty = cur_empty;
                bus.in_byte  = cur_empty ? 8'h00 : cur_msg[idx];
                bus.in_last  = (idx == nbeats - 1);
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                if (idx == nbeats - 1) last_acc_cyc = cyc;
                idx++;
                waitc = 0;
            end else begin
                waitc++;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
        check({name, ".beats"}, 64'(idx), 64'(nbeats));
    endtask

    task automatic consume(input string name);
        int            got;
        int            idle;
        int            stall;
        bit            holding;
        bit            stable;
        logic [1023:0] held;
        logic [1023:0] c;
        logic [1023:0] e;
        got     = 0;
        idle    = 0;
        stall   = 0;
        holding = 0;
        stable  = 1;
        held    = '0;
        first_vld_cyc = -1;
        while (got < exp_q.size() && idle < LIMIT) begin
            @(posedge clk); #1;
            if (stall_cycles > 0)
                bus.chunk_ready = (stall >= stall_cycles);
            else
                bus.chunk_ready = (int'($urandom_range(99)) < rdy_pct);
            @(negedge clk);
            if (bus.chunk_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (holding && bus.chunk !== held) stable = 0;
                held    = bus.chunk;
                holding = 1;
                idle    = 0;
                if (bus.chunk_ready) begin
                    c = bus.chunk;
                    e = exp_q[got];
                    for (int w = 0; w < 16; w++)
                        check($sformatf("%s.b%0d.w%0d", name, got, w),
                              c[1023-64*w -: 64], e[1023-64*w -: 64]);
                    check($sformatf("%s.b%0d.last", name, got),
                          64'(bus.chunk_last), 64'(exp_last[got]));
                    got++;
                    holding = 0;
                    stall   = 0;
                end else begin
                    stall++;
                end
            end else begin
                if (holding) stable = 0;
                holding = 0;
                idle++;
            end
        end
        @(posedge clk); #1;
        bus.chunk_ready = 1'b0;
        check({name, ".blocks"}, 64'(got), 64'(exp_q.size()));
        check({name, ".stable"}, 64'(stable), 64'd1);
    endtask

    task automatic run_msg(input string name, input int stall, input int gap,
                           input int rdy, input bit lat);
        build_expected();
        stall_cycles = stall;
        gap_pct      = gap;
        rdy_pct      = rdy;
        fork
            drive_msg(name);
            consume(name);
        join
        if (lat) check({name, ".latency"}, 64'(first_vld_cyc - last_acc_cyc), 64'd2);
        repeat (2) @(negedge clk);
        check({name, ".idle_valid"}, 64'(bus.chunk_valid), 64'd0);
        check({name, ".idle_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic set_abc();
        cur_msg.delete();
        cur_msg.push_back(8'h61);
        cur_msg.push_back(8'h62);
        cur_msg.push_back(8'h63);
        cur_empty = 0;
    endtask

    task automatic set_random(input int n);
        cur_msg.delete();
        for (int i = 0; i < n; i++) cur_msg.push_back(8'($urandom_range(255)));
        cur_empty = (n == 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        reset           = 1'b0;
        bus.in_byte     = 8'h00;
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.in_empty    = 1'b0;
        bus.chunk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check("rst.chunk_valid", 64'(bus.chunk_valid), 64'd0);
        check("rst.chunk_last", 64'(bus.chunk_last), 64'd0);
        check("rst.chunk_nz", 64'(|bus.chunk), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        set_abc();
        run_msg("abc", 0, 0, 100, 1);

        cur_msg.delete();
        cur_empty = 1;
        run_msg("empty", 0, 0, 100, 1);

        set_random(111);
        run_msg("len111", 0, 20, 70, 0);

        set_random(112);
        run_msg("len112", 0, 20, 70, 0);

        set_random(128);
        run_msg("len128", 5, 0, 100, 0);

        // Reset while a block is waiting for the consumer.
        set_abc();
        gap_pct = 0;
        bus.chunk_ready = 1'b0;
        drive_msg("rstemit");
        w = 0;
        while (!bus.chunk_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rstemit.reached", 64'(bus.chunk_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstemit.chunk_valid", 64'(bus.chunk_valid), 64'd0);
        check("rstemit.chunk_nz", 64'(|bus.chunk), 64'd0);
        check("rstemit.in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_abc();
        run_msg("abc2", 0, 0, 100, 1);

        for (int m = 0; m < 25; m++) begin
            set_random(int'($urandom_range(300)));
            run_msg($sformatf("rnd%0d", m), 0, 30, 60, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
